// File: rtl/spdif_rx.sv
// spdif_rx: S/PDIF (IEC 60958) biphase-mark receiver.
// Classifies pulse widths on the synchronized line, tracks preambles and
// subframes, and emits one 24-bit PCM word per subframe.
// Optional build macro: SPDIF_RX_CHSTAT_EN adds channel-status capture.
// Output protocol: pcm_valid is a 1-cycle strobe with no back-pressure;
// pcm_out, pcm_right, block_start and parity_error are meaningful only
// while it is high. chstat_valid is a 1-cycle strobe coincident with the
// pcm_valid that completes a channel-status block.
module spdif_rx #(
  parameter int CLK_FREQ    = 25175000,
  parameter int SAMPLE_FREQ = 44100,
  parameter int LOCK_COUNT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spdif_in,
  output logic [23:0] pcm_out,
  output logic        pcm_right,
  output logic        pcm_valid,
  output logic        block_start,
  output logic        parity_error,
  output logic        locked,
  output logic [31:0] chstat,
  output logic        chstat_valid,
  output logic [1:0]  dbg_state
);
  // Thresholds use the fractional half-cell length so rounding happens once.
  localparam longint DEN2 = longint'(SAMPLE_FREQ) * 256;
  localparam logic [6:0] TH_G = 7'((longint'(CLK_FREQ) * 1) / DEN2);
  localparam logic [6:0] TH_1 = 7'((longint'(CLK_FREQ) * 3) / DEN2);
  localparam logic [6:0] TH_2 = 7'((longint'(CLK_FREQ) * 5) / DEN2);
  localparam logic [6:0] TH_3 = 7'((longint'(CLK_FREQ) * 7) / DEN2);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0] LOCK_N = GW'(LOCK_COUNT);

  typedef enum logic [1:0] {S_HUNT = 2'd0, S_PRE = 2'd1, S_DATA = 2'd2} state_t;
  typedef enum logic [2:0] {P_NONE = 3'd0, P_1T = 3'd1, P_2T = 3'd2, P_3T = 3'd3,
                            P_GLITCH = 3'd4, P_TMO = 3'd5} pulse_t;
  typedef enum logic [1:0] {PT_B = 2'd1, PT_M = 2'd2, PT_W = 2'd3} ptype_t;
  localparam logic [1:0] PV_NONE = 2'd0, PV_L = 2'd1, PV_R = 2'd2;

  state_t      state_q, state_d;
  logic        s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  pre_idx_q, pre_idx_d;
  logic [3:0]  pre_pat_q, pre_pat_d;
  logic        half_q, half_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [27:0] data_q, data_d;
  ptype_t      ptype_q, ptype_d;
  logic [1:0]  prev_q, prev_d;
  logic [GW-1:0] good_q, good_d;
  logic [23:0] pcm_out_q, pcm_out_d;
  logic        pcm_right_q, pcm_right_d, pcm_valid_q, pcm_valid_d;
  logic        block_start_q, block_start_d, parity_error_q, parity_error_d;
  logic        locked_q, locked_d;

  logic        edge_s, err, sf_done, bit_ok, bit_val, par_bad, seq_err;
  logic [6:0]  elapsed;
  logic [5:0]  pre_full;
  logic [GW-1:0] good_inc;
  pulse_t      pc;

  // Synchronizer, edge detector and saturating width counter.
  always_comb begin
    s1_d    = spdif_in;
    s2_d    = s1_q;
    s3_d    = s2_q;
    edge_s  = s2_q ^ s3_q;
    elapsed = {1'b0, cnt_q} + 7'd1;
    if (edge_s)              cnt_d = 6'd0;
    else if (cnt_q == 6'h3f) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + 6'd1;
  end

  // Pulse-width classification; timeout fires even without an edge.
  always_comb begin
    pc = P_NONE;
    if (elapsed > TH_3) pc = P_TMO;
    else if (edge_s) begin
      if (elapsed < TH_G)       pc = P_GLITCH;
      else if (elapsed <= TH_1) pc = P_1T;
      else if (elapsed <= TH_2) pc = P_2T;
      else                      pc = P_3T;
    end
  end

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HUNT; s1_q <= 1'b0; s2_q <= 1'b0; s3_q <= 1'b0; cnt_q <= '0;
      pre_idx_q <= '0; pre_pat_q <= '0; half_q <= 1'b0; bit_cnt_q <= '0;
      data_q <= '0; ptype_q <= PT_B; prev_q <= PV_NONE; good_q <= '0;
      pcm_out_q <= '0; pcm_right_q <= 1'b0; pcm_valid_q <= 1'b0;
      block_start_q <= 1'b0; parity_error_q <= 1'b0; locked_q <= 1'b0;
    end else begin
      state_q <= state_d; s1_q <= s1_d; s2_q <= s2_d; s3_q <= s3_d; cnt_q <= cnt_d;
      pre_idx_q <= pre_idx_d; pre_pat_q <= pre_pat_d; half_q <= half_d;
      bit_cnt_q <= bit_cnt_d; data_q <= data_d; ptype_q <= ptype_d;
      prev_q <= prev_d; good_q <= good_d;
      pcm_out_q <= pcm_out_d; pcm_right_q <= pcm_right_d; pcm_valid_q <= pcm_valid_d;
      block_start_q <= block_start_d; parity_error_q <= parity_error_d;
      locked_q <= locked_d;
    end
  end

  // Next-state: preamble matching and biphase-mark bit decoding.
  always_comb begin
    state_d = state_q; pre_idx_d = pre_idx_q; pre_pat_d = pre_pat_q;
    half_d = half_q; bit_cnt_d = bit_cnt_q; data_d = data_q; ptype_d = ptype_q;
    err = (pc == P_GLITCH) || (pc == P_TMO);
    sf_done = 1'b0; bit_ok = 1'b0; bit_val = 1'b0;
    pre_full = {pre_pat_q, pc[1:0]};
    if (!err && pc != P_NONE) begin
      case (state_q)
        S_HUNT: if (pc == P_3T) begin state_d = S_PRE; pre_idx_d = 2'd1; end
        S_PRE: begin
          if (pre_idx_q == 2'd0) begin
            if (pc == P_3T) pre_idx_d = 2'd1;
            else err = 1'b1;
          end else if (pre_idx_q == 2'd3) begin
            state_d = S_DATA; half_d = 1'b0; bit_cnt_d = 5'd0;
            case (pre_full)
              6'b01_01_11: ptype_d = PT_B;
              6'b11_01_01: ptype_d = PT_M;
              6'b10_01_10: ptype_d = PT_W;
              default:     err = 1'b1;
            endcase
          end else begin
            pre_pat_d = {pre_pat_q[1:0], pc[1:0]};
            pre_idx_d = pre_idx_q + 2'd1;
          end
        end
        S_DATA: begin
          if (pc == P_1T) begin
            if (!half_q) half_d = 1'b1;
            else begin half_d = 1'b0; bit_ok = 1'b1; bit_val = 1'b1; end
          end else if (pc == P_2T && !half_q) bit_ok = 1'b1;
          else err = 1'b1;
          if (bit_ok) begin
            data_d    = {bit_val, data_q[27:1]};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd27) begin
              sf_done = 1'b1; state_d = S_PRE; pre_idx_d = 2'd0; bit_cnt_d = 5'd0;
            end
          end
        end
        default: err = 1'b1;
      endcase
    end
    if (err) begin
      state_d = S_HUNT; pre_idx_d = 2'd0; half_d = 1'b0; bit_cnt_d = 5'd0;
    end
  end

  // Outputs: strobe, parity, preamble ordering and lock tracking.
  always_comb begin
    pcm_out_d = pcm_out_q; pcm_right_d = pcm_right_q; pcm_valid_d = 1'b0;
    block_start_d = block_start_q; parity_error_d = parity_error_q;
    locked_d = locked_q; good_d = good_q; prev_d = prev_q;
    par_bad = ^data_d;
    seq_err = ((prev_q == PV_L) && (ptype_q != PT_W)) ||
              ((prev_q == PV_R) && (ptype_q == PT_W));
    good_inc = (good_q == LOCK_N) ? good_q : good_q + GW'(1);
    if (sf_done) begin
      pcm_valid_d    = 1'b1;
      pcm_out_d      = data_d[23:0];
      pcm_right_d    = (ptype_q == PT_W);
      block_start_d  = (ptype_q == PT_B);
      parity_error_d = par_bad;
      prev_d         = (ptype_q == PT_W) ? PV_R : PV_L;
      if (seq_err) begin
        locked_d = 1'b0;
        good_d   = par_bad ? GW'(0) : GW'(1);
      end else if (!par_bad) begin
        good_d = good_inc;
        if (good_inc == LOCK_N) locked_d = 1'b1;
      end
    end else if (err) begin
      locked_d = 1'b0; good_d = '0; prev_d = PV_NONE;
    end
  end

`ifdef SPDIF_RX_CHSTAT_EN
  logic [4:0]  fcnt_q, fcnt_d;
  logic        blk_q, blk_d, chstat_valid_q, chstat_valid_d;
  logic [31:0] csh_q, csh_d, chstat_q, chstat_d;

  // Channel-status flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q <= '0; blk_q <= 1'b0; csh_q <= '0; chstat_q <= '0; chstat_valid_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d; blk_q <= blk_d; csh_q <= csh_d;
      chstat_q <= chstat_d; chstat_valid_q <= chstat_valid_d;
    end
  end

  // Collect the C bit of each left subframe; frame 0 starts at a B preamble.
  always_comb begin
    fcnt_d = fcnt_q; blk_d = blk_q; csh_d = csh_q;
    chstat_d = chstat_q; chstat_valid_d = 1'b0;
    if (sf_done && ptype_q != PT_W) begin
      csh_d = {data_d[26], csh_q[31:1]};
      if (ptype_q == PT_B) begin
        fcnt_d = 5'd1; blk_d = 1'b1;
      end else begin
        fcnt_d = fcnt_q + 5'd1;
        if (blk_q && fcnt_q == 5'd31 && !seq_err && !par_bad) begin
          chstat_d = csh_d; chstat_valid_d = 1'b1; blk_d = 1'b0;
        end
      end
    end
    if ((sf_done && (seq_err || par_bad)) || err) blk_d = 1'b0;
  end

  assign chstat       = chstat_q;
  assign chstat_valid = chstat_valid_q;
`else
  assign chstat       = 32'd0;
  assign chstat_valid = 1'b0;
`endif

  assign pcm_out      = pcm_out_q;
  assign pcm_right    = pcm_right_q;
  assign pcm_valid    = pcm_valid_q;
  assign block_start  = block_start_q;
  assign parity_error = parity_error_q;
  assign locked       = locked_q;
  assign dbg_state    = state_q;
endmodule
